// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared constants and config helpers for seq_detect_param
package seq_detect_pkg;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  function automatic logic len_valid(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter; a clear in the same cycle as an
// increment yields 1 (clear first, then count)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] base;

  always_comb begin
    base    = clr ? '0 : count_q;
    count_d = base;
    if (inc && (base != {W{1'b1}})) begin
      count_d = base + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - run-time programmable serial pattern detector with
// overlap control, registered match pulse and saturating match counter
module seq_detect_param #(
  parameter int               MAX_LEN     = 8,
  parameter int               CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_0101,
  parameter int               RST_LEN     = 3,
  parameter logic             RST_OVERLAP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_in,
  input  logic                         data_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         sequence_detected,
  output logic [CNT_W-1:0]             match_count,
  output logic                         cfg_err
);

  import seq_detect_pkg::*;

  localparam int LW = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] hist_q, hist_d, hist_n;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] len_mask;
  logic [LW-1:0]      fill_q, fill_d, fill_n;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               det_q, det_d;
  logic               err_q, err_d;
  logic               cfg_ok;
  logic               match;

  always_comb begin
    cfg_ok   = len_valid(32'(cfg_len), MAX_LEN);
    hist_n   = {hist_q[MAX_LEN-2:0], data_in};
    fill_n   = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
    // Only the low len bits take part in the compare; higher history bits are don't-care.
    len_mask = ~({MAX_LEN{1'b1}} << len_q);
    match    = data_valid && !cfg_load && (fill_n >= len_q) &&
               (((hist_n ^ pat_q) & len_mask) == '0);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    det_d  = match;
    err_d  = 1'b0;

    if (cfg_load) begin
      if (cfg_ok) begin
        pat_d  = cfg_pattern;
        len_d  = cfg_len;
        ovl_d  = cfg_overlap;
        hist_d = '0;
        fill_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (data_valid) begin
      hist_d = hist_n;
      // Non-overlap mode: the next match must be built entirely from fresh bits.
      fill_d = (match && (ovl_q == OVL_OFF)) ? '0 : fill_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PATTERN;
      len_q  <= LW'(RST_LEN);
      ovl_q  <= RST_OVERLAP;
      det_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      det_q  <= det_d;
      err_q  <= err_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (match),
    .count(match_count)
  );

  assign sequence_detected = det_q;
  assign cfg_err           = err_q;

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised, run-time programmable serial pattern detector.
- Successor to the fixed "101" detector. Pattern value, length (1..MAX_LEN) and overlap/non-overlap mode are set at run time.
- Adds a data_valid qualifier, a one-cycle match pulse, a saturating match counter and configuration-error flagging.
- Sits on a serial bit stream behind a deserialiser/sampler; counter and config are driven by the local control block.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- CNT_W, 16: match counter width.
- RST_PATTERN, 8'b0000_0101: pattern after reset. Low RST_LEN bits are used.
- RST_LEN, 3: pattern length after reset (1..MAX_LEN).
- RST_OVERLAP, 1: overlap mode after reset. 1 = overlapping matches allowed.

Ports:
- clk  in  1  Single clock; all logic is on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- data_in  in  1  Serial data bit.
- data_valid  in  1  data_in is sampled only when high.
- cfg_load  in  1  One-cycle strobe that latches cfg_*.
- cfg_pattern  in  MAX_LEN  New pattern. Bit [len-1] is the first bit received; bit [0] is the last.
- cfg_len  in  $clog2(MAX_LEN+1)  New pattern length.
- cfg_overlap  in  1  New overlap mode.
- cnt_clr  in  1  Clears the match counter.
- sequence_detected  out  1  Registered one-cycle match pulse.
- match_count  out  CNT_W  Saturating count of matches.
- cfg_err  out  1  One-cycle pulse when cfg_load is rejected.

Behaviour:
- Reset: when rst is high at a clock edge:
  - history and fill count clear to 0.
  - Config takes the RST_* values.
  - sequence_detected=0, match_count=0, cfg_err=0.
  - Reset mid-stream discards partial matches; the next valid bit is treated as bit 1.
- State:
  - hist[MAX_LEN-1:0] shift register.
  - fill counter 0..MAX_LEN, saturating, giving the number of valid bits since the last clear.
  - Active config registers: pat, len, ovl.
- Valid bit (data_valid=1, no cfg_load):
  - hist_n = {hist[MAX_LEN-2:0], data_in}.
  - fill_n = min(fill+1, MAX_LEN).
  - match = (fill_n >= len) && (hist_n[len-1:0] == pat[len-1:0]). Bits above len are don't-care.
- On match:
  - sequence_detected = 1 in the cycle after the sampling edge. Latency is 1 clock, as a registered Moore-style output.
  - If ovl=1, history and fill are kept.
  - If ovl=0, fill is forced to 0 so the next match needs len fresh bits. hist still shifts.
- data_valid=0: hist and fill hold, sequence_detected=0. Gaps never break a partial match.
- sequence_detected is high for exactly one cycle per match. Back-to-back matches give consecutive pulses (e.g. len=1, or overlap mode with periodic patterns).
- cfg_load, accepted when 1 <= cfg_len <= MAX_LEN:
  - pat, len and ovl update at the edge.
  - hist and fill clear.
  - sequence_detected=0 next cycle.
  - match_count is not affected.
- cfg_load, rejected when cfg_len is 0 or > MAX_LEN:
  - Config, hist and fill are unchanged.
  - cfg_err=1 for one cycle.
- cfg_load together with data_valid: cfg_load wins and the data bit is discarded.
- match_count:
  - Increments on each match and saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr alone sets it to 0.
  - cnt_clr together with a match sets it to 1: the clear applies first, then the match is counted.

Decomposition:
- seq_detect_pkg: localparams OVL_ON=1'b1 and OVL_OFF=1'b0, plus a function len_valid(len, max) used by the RTL and the bench.
- Sub-module sat_counter (params W; ports clk, rst, clr, inc, count), implementing the clear-then-increment priority.
- Compare/mask logic and the fill/history datapath stay in the top module.

Test Plan:
- Reset defaults (101, overlap); valid stream 1,0,1,0,1 -> sequence_detected pulses 1 cycle after bits 3 and 5; match_count=2.
- cfg_load pattern 101, len 3, ovl=0; stream 1,0,1,0,1 -> single pulse after bit 3, none after bit 5; match_count=1.
- cfg_load 8'hA5, len 8; send 1,0,1,0,0,1,0,1 with data_valid=0 gaps of 0-3 cycles between bits -> exactly one pulse, 1 cycle after the 8th valid bit; no pulse during the gaps.
- Stream 1,0, then cfg_load pattern 2'b11 len 2 with data_valid=1 on the same cycle, then 1,1 -> the strobe-cycle bit is discarded; no pulse on the first 1; pulse after the second 1.
- cfg_load with cfg_len=0, then with cfg_len=9 -> cfg_err pulses once each; 101 detection is still correct afterwards.
- CNT_W=2, 5 matches -> match_count=3 (saturated). cnt_clr on the same cycle as a match -> match_count=1. Assert rst mid-pattern (after 1,0), then send 1 -> no pulse, all outputs 0.
